// File: rtl/gf2m_pkg.sv
// gf2m_pkg: GF(2^m) field constants, inverter FSM states and sizing helpers.
// Shared by the inverter and the digit-serial multiplier.
package gf2m_pkg;

   localparam int           M163    = 163;
   localparam logic [162:0] POLY163 = 163'h0C9;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL,
      WB,
      FIN
   } inv_state_t;

   function automatic int k_of(input int m, input int d);
      return (m + d - 1) / d;
   endfunction

endpackage

// File: rtl/gf2m_digit_mult.sv
// gf2m_digit_mult: MSB-first digit-serial GF(2^m) multiplier, p = a*b mod f.
// The load cycle consumes the first digit; K cycles in total per product.
module gf2m_digit_mult
   import gf2m_pkg::*;
#(
   parameter int           M    = M163,
   parameter logic [M-1:0] POLY = M'(POLY163),
   parameter int           D    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         busy,
   output logic [M-1:0] p,
   output logic         valid
);

   localparam int K  = k_of(M, D);
   localparam int KD = K * D;
   localparam int CW = $clog2(K + 1);

   logic [M-1:0]  a_r;
   logic [KD-1:0] b_r;
   logic [KD-1:0] b_ext;
   logic [CW-1:0] cnt;

   // b is zero-padded on the MSB side so the digit count is always K
   assign b_ext = KD'(b);

   function automatic logic [M-1:0] step(
      input logic [M-1:0] acc,
      input logic [M-1:0] x,
      input logic [D-1:0] dig
   );
      logic [M-1:0] r;
      r = acc;
      for (int j = D - 1; j >= 0; j--) begin
         r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
         if (dig[j]) r = r ^ x;
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         cnt   <= '0;
         p     <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (load) begin
            a_r <= a;
            p   <= step('0, a, b_ext[KD-1 -: D]);
            b_r <= b_ext << D;
            cnt <= CW'(K - 1);
            if (K == 1) begin
               busy  <= 1'b0;
               valid <= 1'b1;
            end else begin
               busy <= 1'b1;
            end
         end else if (busy) begin
            p   <= step(p, a_r, b_r[KD-1 -: D]);
            b_r <= b_r << D;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy  <= 1'b0;
               valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gf2m_inv_seq.sv
// gf2m_inv_seq: sequential GF(2^m) inverter, a^(2^m-2) over one shared multiplier.
// Optional GF2M_INV_ZERO_FLAG_EN: zero operand finishes early with zero_err.
module gf2m_inv_seq
   import gf2m_pkg::*;
#(
   parameter int           M    = M163,
   parameter logic [M-1:0] POLY = M'(POLY163),
   parameter int           D    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [M-1:0] inv_inp,
   output logic         busy,
   output logic         done,
`ifdef GF2M_INV_ZERO_FLAG_EN
   output logic         zero_err,
`endif
   output logic [M-1:0] inv_out
);

   localparam int K    = k_of(M, D);
   localparam int NOPS = 2 * M - 2;
   localparam int JW   = $clog2(2 * M);
   localparam int CW   = $clog2(K + 1);

   inv_state_t    state;
   logic [M-1:0]  sq;
   logic [M-1:0]  res;
   logic [JW-1:0] j;
   logic [CW-1:0] dcnt;

   logic          mul_load;
   logic [M-1:0]  mul_a;
   logic          mul_busy;
   logic [M-1:0]  mul_p;
   logic          mul_valid;

   // even ops square sq, odd ops fold sq into res (res starts at 1)
   always_comb begin
      mul_a    = j[0] ? res : sq;
      mul_load = (state == LOAD) && !mul_busy;
`ifdef GF2M_INV_ZERO_FLAG_EN
      if (sq == '0) mul_load = 1'b0;
`endif
   end

   gf2m_digit_mult #(
      .M    (M),
      .POLY (POLY),
      .D    (D)
   ) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (mul_load),
      .a     (mul_a),
      .b     (sq),
      .busy  (mul_busy),
      .p     (mul_p),
      .valid (mul_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sq       <= '0;
         res      <= '0;
         j        <= '0;
         dcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         inv_out  <= '0;
`ifdef GF2M_INV_ZERO_FLAG_EN
         zero_err <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  sq       <= inv_inp;
                  res      <= M'(1);
                  j        <= '0;
`ifdef GF2M_INV_ZERO_FLAG_EN
                  zero_err <= 1'b0;
`endif
               end
            end
            LOAD: begin
`ifdef GF2M_INV_ZERO_FLAG_EN
               if (sq == '0) begin
                  state    <= FIN;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  inv_out  <= '0;
                  zero_err <= 1'b1;
               end else
`endif
               begin
                  dcnt  <= CW'(K - 1);
                  state <= (K == 1) ? WB : MUL;
               end
            end
            MUL: begin
               if (dcnt == CW'(1)) state <= WB;
               else dcnt <= dcnt - 1'b1;
            end
            WB: begin
               if (mul_valid) begin
                  if (j[0]) res <= mul_p;
                  else sq <= mul_p;
               end
               if (j == JW'(NOPS - 1)) begin
                  state   <= FIN;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  inv_out <= mul_p;
               end else begin
                  j     <= j + 1'b1;
                  state <= LOAD;
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m_inv_seq.sv
// tb_gf2m_inv_seq: scoreboard bench, B-163 with D=8 and a 4-bit field with D=1.
// Expected inverses come from a binary extended-Euclid model.
module tb_gf2m_inv_seq;

   localparam int           BM    = 163;
   localparam int           BD    = 8;
   localparam int           BK    = (BM + BD - 1) / BD;
   localparam int           BL    = 1 + (2 * BM - 2) * (BK + 1);
   localparam logic [162:0] BPOLY = 163'h0C9;
   localparam logic [163:0] F_BIG = {1'b1, BPOLY};
   localparam int           SM    = 4;
   localparam int           SL    = 31;
   localparam logic [3:0]   SPOLY = 4'h3;
   localparam logic [163:0] F_SM  = 164'h13;
   localparam logic [162:0] X_INV = 163'h4_0000000000_0000000000_0000000000_0000000064;
   localparam logic [162:0] RND1  = 163'h7_FEDCBA0987654321_0F1E2D3C4B5A6978_89ABCDEF;

   typedef struct {
      logic [162:0] val;
      int           start;
      int           due;
      logic         zf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          b_start, b_busy, b_done;
   logic [BM-1:0] b_inp, b_out;
   logic          s_start, s_busy, s_done;
   logic [SM-1:0] s_inp, s_out;
`ifdef GF2M_INV_ZERO_FLAG_EN
   logic          b_zerr, s_zerr;
`endif

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   b_ndone = 0;
   int   s_ndone = 0;
   int   b_lo = 0;
   int   s_lo = 0;
   exp_t bq[$];
   exp_t sq[$];
   exp_t be, se;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gf2m_inv_seq #(.M(BM), .POLY(BPOLY), .D(BD)) u_big (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (b_start),
      .inv_inp  (b_inp),
      .busy     (b_busy),
      .done     (b_done),
`ifdef GF2M_INV_ZERO_FLAG_EN
      .zero_err (b_zerr),
`endif
      .inv_out  (b_out)
   );

   gf2m_inv_seq #(.M(SM), .POLY(SPOLY), .D(1)) u_small (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (s_start),
      .inv_inp  (s_inp),
      .busy     (s_busy),
      .done     (s_done),
`ifdef GF2M_INV_ZERO_FLAG_EN
      .zero_err (s_zerr),
`endif
      .inv_out  (s_out)
   );

   task automatic chk(input string name, input logic [162:0] act, input logic [162:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // binary extended Euclid over GF(2)[x]; f includes the x^m term
   function automatic logic [163:0] inv_ref(input logic [163:0] a, input logic [163:0] f);
      logic [163:0] u, v, g1, g2;
      if (a == '0) return '0;
      u = a; v = f; g1 = 164'd1; g2 = '0;
      for (int it = 0; it < 4000 && u != 164'd1 && v != 164'd1; it++) begin
         while (!u[0]) begin
            u  = u >> 1;
            g1 = g1[0] ? (g1 ^ f) >> 1 : g1 >> 1;
         end
         while (!v[0]) begin
            v  = v >> 1;
            g2 = g2[0] ? (g2 ^ f) >> 1 : g2 >> 1;
         end
         if (u > v) begin u = u ^ v; g1 = g1 ^ g2; end
         else begin v = v ^ u; g2 = g2 ^ g1; end
      end
      return (u == 164'd1) ? g1 : g2;
   endfunction

   function automatic logic [162:0] rand_operand();
      logic [191:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      w[0] = 1'b1;
      return w[162:0];
   endfunction

   always @(negedge clk) begin
      if (rst_n && b_done) begin
         if (bq.size() == 0) begin
            checks++; failures++;
            $display("FAIL big_spurious_done: actual=done required=no_done");
         end else begin
            be = bq.pop_front();
            chk("big_result", b_out, be.val);
            chk("big_latency", 163'(cyc - be.start), 163'(be.due - be.start));
            chk("big_busy_run_low_cycles", 163'(b_lo), '0);
            chk("big_busy_at_done", {162'd0, b_busy}, '0);
`ifdef GF2M_INV_ZERO_FLAG_EN
            chk("big_zero_err", {162'd0, b_zerr}, {162'd0, be.zf});
`endif
            b_lo = 0;
            b_ndone++;
         end
      end else if (rst_n && bq.size() != 0 && !b_busy && cyc > bq[0].start && cyc < bq[0].due)
         b_lo++;
   end

   always @(negedge clk) begin
      if (rst_n && s_done) begin
         if (sq.size() == 0) begin
            checks++; failures++;
            $display("FAIL small_spurious_done: actual=done required=no_done");
         end else begin
            se = sq.pop_front();
            chk("small_result", {159'd0, s_out}, se.val);
            chk("small_latency", 163'(cyc - se.start), 163'(se.due - se.start));
            chk("small_busy_run_low_cycles", 163'(s_lo), '0);
`ifdef GF2M_INV_ZERO_FLAG_EN
            chk("small_zero_err", {162'd0, s_zerr}, {162'd0, se.zf});
`endif
            s_lo = 0;
            s_ndone++;
         end
      end else if (rst_n && sq.size() != 0 && !s_busy && cyc > sq[0].start && cyc < sq[0].due)
         s_lo++;
   end

   // mode 1: extra start mid-run; mode 2: start held in the done cycle
   task automatic big_op(input logic [162:0] a, input int mode);
      exp_t         e;
      logic [163:0] r;
      int           n0, lat;
      lat = BL;
`ifdef GF2M_INV_ZERO_FLAG_EN
      if (a == '0) lat = 2;
`endif
      r = inv_ref({1'b0, a}, F_BIG);
      e.val = (a == 163'd2) ? X_INV : r[162:0];
      e.zf  = (a == '0);
      @(negedge clk);
      b_inp = a;
      b_start = 1'b1;
      e.start = cyc;
      e.due = cyc + lat;
      n0 = b_ndone;
      bq.push_back(e);
      do begin
         @(negedge clk);
         b_start = (mode == 1 && cyc == e.start + lat / 2) || (mode == 2 && cyc == e.due);
         b_inp = ~a;
         if (mode == 2 && cyc == e.due + 1)
            chk("big_start_in_done_ignored", {162'd0, b_busy}, '0);
      end while (cyc < e.due + 2);
      b_start = 1'b0;
      if (b_ndone == n0) begin
         checks++; failures++;
         $display("FAIL big_timeout: actual=no_done required=done_by_cycle_%0d", e.due);
         bq.delete();
      end
   endtask

   task automatic small_op(input logic [3:0] a);
      exp_t         e;
      logic [163:0] r;
      int           n0, lat;
      lat = SL;
`ifdef GF2M_INV_ZERO_FLAG_EN
      if (a == 4'd0) lat = 2;
`endif
      r = inv_ref({160'd0, a}, F_SM);
      e.val = (a == 4'd2) ? 163'h9 : r[162:0];
      e.zf  = (a == 4'd0);
      @(negedge clk);
      s_inp = a;
      s_start = 1'b1;
      e.start = cyc;
      e.due = cyc + lat;
      n0 = s_ndone;
      sq.push_back(e);
      @(negedge clk);
      s_start = 1'b0;
      s_inp = ~a;
      while (cyc < e.due + 2) @(negedge clk);
      if (s_ndone == n0) begin
         checks++; failures++;
         $display("FAIL small_timeout: actual=no_done required=done_by_cycle_%0d", e.due);
         sq.delete();
      end
   endtask

   initial begin
      b_start = 1'b0; b_inp = '0;
      s_start = 1'b0; s_inp = '0;
      repeat (2) @(negedge clk);
      chk("rst_big_busy", {162'd0, b_busy}, '0);
      chk("rst_big_done", {162'd0, b_done}, '0);
      chk("rst_big_out", b_out, '0);
      chk("rst_small_busy", {162'd0, s_busy}, '0);
      chk("rst_small_out", {159'd0, s_out}, '0);
`ifdef GF2M_INV_ZERO_FLAG_EN
      chk("rst_big_zero_err", {162'd0, b_zerr}, '0);
`endif
      rst_n = 1'b1;
      fork
         begin
            big_op(163'd1, 0);
            big_op(163'd2, 0);
            big_op(RND1, 1);
         end
         begin
            for (int a = 0; a < 16; a++) small_op(4'(a));
         end
      join
      big_op(163'd0, 2);
      big_op(rand_operand(), 0);

      @(negedge clk);
      b_inp = rand_operand();
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      repeat (BL / 3) @(negedge clk);
      #2 rst_n = 1'b0;
      bq.delete();
      b_lo = 0;
      #1;
      chk("rst_mid_busy", {162'd0, b_busy}, '0);
      chk("rst_mid_done", {162'd0, b_done}, '0);
      chk("rst_mid_out", b_out, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (BL) @(negedge clk);
      big_op(rand_operand(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
